// File: rtl/div_seq_pkg.sv
// Shared word type, FSM state encoding and sign helper for the sequential divider.
package div_seq_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t      ZERO_WORD = '0;
    localparam logic [4:0] CNT_LAST  = 5'd31;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    function automatic word_t neg_if(input word_t v, input logic n);
        return n ? (ZERO_WORD - v) : v;
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// ALU <-> divider handshake: request/operands/control in, ready and results out.
interface div_seq_if;
    import div_seq_pkg::*;

    logic  start;
    logic  sign;
    word_t opr1;
    word_t opr2;
    logic  ex_hold;
    logic  flush;
    logic  ready;
    word_t quot;
    word_t rem;

    modport master (
        output start, sign, opr1, opr2, ex_hold, flush,
        input  ready, quot, rem
    );

    modport slave (
        input  start, sign, opr1, opr2, ex_hold, flush,
        output ready, quot, rem
    );

endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, results
// and ready registered, hold while EX is frozen, abort on flush.
module div_seq
    import div_seq_pkg::*;
(
    input logic      clk,
    input logic      rst,
    div_seq_if.slave div
);

    div_state_e state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] prem_q, prem_d;
    word_t       dvd_q, dvd_d;
    word_t       dsr_q, dsr_d;
    logic        dneg_q, dneg_d;
    logic        vneg_q, vneg_d;
    logic        ready_q, ready_d;
    word_t       quot_q, quot_d;
    word_t       rem_q, rem_d;

    // One restoring step; the partial remainder stays below the divisor, so
    // the top bit of the difference is the borrow.
    logic [33:0] shifted, diff;
    logic        qbit;
    logic [32:0] prem_step;
    word_t       quo_step;

    always_comb begin
        shifted   = {prem_q, dvd_q[WORD_W-1]};
        diff      = shifted - {2'b00, dsr_q};
        qbit      = ~diff[33];
        prem_step = qbit ? diff[32:0] : shifted[32:0];
        quo_step  = {dvd_q[WORD_W-2:0], qbit};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        dneg_d  = dneg_q;
        vneg_d  = vneg_q;
        ready_d = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;

        if (div.flush) begin
            state_d = DIV_IDLE;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (div.start) begin
                        dneg_d = div.sign & div.opr1[WORD_W-1];
                        vneg_d = div.sign & div.opr2[WORD_W-1];
                        dvd_d  = neg_if(div.opr1, dneg_d);
                        dsr_d  = neg_if(div.opr2, vneg_d);
                        if (div.opr2 == ZERO_WORD) begin
                            state_d = DIV_DONE;
                            ready_d = 1'b1;
                            quot_d  = '1;
                            rem_d   = div.opr1;
                        end else begin
                            state_d = DIV_CALC;
                            cnt_d   = '0;
                            prem_d  = '0;
                        end
                    end
                end
                DIV_CALC: begin
                    cnt_d  = cnt_q + 5'd1;
                    prem_d = prem_step;
                    dvd_d  = quo_step;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DIV_DONE;
                        ready_d = 1'b1;
                        quot_d  = neg_if(quo_step, dneg_q ^ vneg_q);
                        rem_d   = neg_if(prem_step[WORD_W-1:0], dneg_q);
                    end
                end
                DIV_DONE: begin
                    if (div.ex_hold) begin
                        ready_d = 1'b1;
                    end else begin
                        state_d = DIV_IDLE;
                    end
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            dneg_q  <= 1'b0;
            vneg_q  <= 1'b0;
            ready_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            dneg_q  <= dneg_d;
            vneg_q  <= vneg_d;
            ready_q <= ready_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign div.ready = ready_q;
    assign div.quot  = quot_q;
    assign div.rem   = rem_q;

endmodule
